instr_encoder: RTL and testbench
================================

# instr_encoder

Streaming MIPS instruction encoder and instruction-memory loader: the inverse of the control decoder. It accepts one symbolic instruction per handshake (mnemonic code plus fields), packs it into a 32-bit MIPS machine word and writes it to consecutive instruction-memory words starting at word 0. It sits between the testbench/boot source and the IM write port. It covers exactly the instruction set the CPU's control unit decodes.

## Interface
- ADDR_W, 8, IM word-address width; capacity DEPTH = 2**ADDR_W words
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a new load session (ignored while RUN)
- in_valid  in  1  instruction beat valid
- in_ready  out  1  encoder accepts beat; transfer when in_valid & in_ready
- in_mnem  in  5  mnemonic code (see Operation)
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shamt fields
- in_imm  in  16  immediate / branch offset
- in_target  in  26  jump target field
- im_we  out  1  IM write strobe
- im_addr  out  ADDR_W  IM word address
- im_wdata  out  32  encoded instruction word
- count  out  ADDR_W+1  words written this session
- busy  out  1  state == RUN
- done  out  1  state == DONE
- err  out  1  state == ERR
- err_code  out  2  01 illegal mnemonic, 10 overflow, 00 none

## Operation
- Mnemonic codes: 0 add, 1 addu, 2 sub, 3 subu, 4 and, 5 or, 6 xor, 7 nor, 8 slt, 9 sltu, 10 sll, 11 srl, 12 sra, 13 sllv, 14 srlv, 15 srav, 16 jr, 17 jalr, 18 addi, 19 slti, 20 andi, 21 ori, 22 lui, 23 lw, 24 sw, 25 beq, 26 bne, 27 j, 28 jal, 29–30 illegal, 31 END.
- R-type: op=000000; funct sll 00, srl 02, sra 03, sllv 04, srlv 06, srav 07, jr 08, jalr 09, add 20, addu 21, sub 22, subu 23, and 24, or 25, xor 26, nor 27, slt 2A, sltu 2B (hex).
- I/J opcodes: j 02, jal 03, beq 04, bne 05, addi 08, slti 0A, andi 0C, ori 0D, lui 0F, lw 23, sw 2B (hex). I-type word = op|rs|rt|imm; J-type = op|target.
- Field forcing (unused fields written as 0): R non-shift-imm → shamt=0; sll/srl/sra → rs=0; jr → rt=rd=shamt=0; jalr → rt=shamt=0; lui → rs=0.
- FSM states IDLE, RUN, DONE, ERR. Reset → IDLE.
- IDLE/DONE/ERR + start → RUN; count=0, next address 0, err_code=00.
- RUN: in_ready=1 always. Accepted legal beat with count<DEPTH → write issued, count+1. Accepted END → DONE, no write. Accepted illegal code → ERR, err_code=01, no write. Accepted legal beat with count==DEPTH → ERR, err_code=10, no write. END with count==DEPTH → DONE (legal).
- in_ready=0 in IDLE, DONE, ERR. start in RUN ignored.

## Timing
- Reset values: in_ready 0, im_we 0, im_addr 0, im_wdata 0, count 0, busy/done/err 0, err_code 00.
- Latency 1: beat accepted at edge N → im_we=1 with im_addr/im_wdata valid during cycle N+1 (registered). im_we is a single-cycle strobe per word; throughput one word/cycle.
- im_addr = count value before increment; no wrap-around: address DEPTH-1 is last written, never 0 again in a session.
- count, busy/done/err, err_code update on the same edge as acceptance.
- Simultaneous start and in_valid in IDLE: start takes effect; beat not accepted (in_ready was 0).
- rst asserted mid-session: all outputs return to reset values at that edge; any pending write strobe is dropped.
- done/err are levels held until start or rst.

## Structure
- Package mips_enc_pkg: mnemonic code localparams (incl. MN_END=31), opcode and funct localparams, FSM state encoding, err_code values.
- Sub-module instr_pack: combinational mnemonic+fields → {legal, is_end, word[31:0]}, including field forcing. instr_encoder holds FSM, counter and output registers.

## Test plan
- start, addi mnem=18 rs=0 rt=8 imm=0x0005 → next cycle im_we=1, im_addr=0, im_wdata=0x20080005; count=1.
- Back-to-back add (rs=8,rt=9,rd=10,shamt=3) then sll (rs=7,rt=8,rd=9,shamt=2) → 0x01095020 @0, 0x00084880 @1 on consecutive cycles.
- lw rs=29 rt=8 imm=4; beq rs=8 rt=0 imm=0xFFFF; j target=0x10; END → 0x8FA80004, 0x1100FFFF, 0x08000010 at 0..2; done=1, count=3, no 4th strobe.
- ADDR_W=2: four addu then a fifth beat → 4 strobes (addr 0..3), fifth not written, err=1, err_code=10, in_ready=0.
- Beat with mnem=29 → no strobe, err_code=01; then start → err=0, busy=1, count=0.
- rst during RUN the cycle a beat is accepted → im_we=0 next cycle, all outputs at reset values.

Source files
------------

// File: rtl/mips_enc_pkg.sv
// mips_enc_pkg: mnemonic, opcode and funct codes, FSM states and error codes for the instruction encoder
package mips_enc_pkg;
  localparam logic [4:0] MN_ADD = 5'd0, MN_ADDU = 5'd1, MN_SUB = 5'd2, MN_SUBU = 5'd3;
  localparam logic [4:0] MN_AND = 5'd4, MN_OR = 5'd5, MN_XOR = 5'd6, MN_NOR = 5'd7;
  localparam logic [4:0] MN_SLT = 5'd8, MN_SLTU = 5'd9, MN_SLL = 5'd10, MN_SRL = 5'd11;
  localparam logic [4:0] MN_SRA = 5'd12, MN_SLLV = 5'd13, MN_SRLV = 5'd14, MN_SRAV = 5'd15;
  localparam logic [4:0] MN_JR = 5'd16, MN_JALR = 5'd17, MN_ADDI = 5'd18, MN_SLTI = 5'd19;
  localparam logic [4:0] MN_ANDI = 5'd20, MN_ORI = 5'd21, MN_LUI = 5'd22, MN_LW = 5'd23;
  localparam logic [4:0] MN_SW = 5'd24, MN_BEQ = 5'd25, MN_BNE = 5'd26, MN_J = 5'd27;
  localparam logic [4:0] MN_JAL = 5'd28, MN_END = 5'd31;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI = 6'h0D, OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR = 6'h08, FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A, FN_SLTU = 6'h2B;
  localparam logic [1:0] EC_NONE = 2'b00, EC_ILLEGAL = 2'b01, EC_OVERFLOW = 2'b10;
  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;
  function automatic logic [5:0] funct_of(input logic [4:0] m);
    case (m)
      MN_ADD:  return FN_ADD;
      MN_ADDU: return FN_ADDU;
      MN_SUB:  return FN_SUB;
      MN_SUBU: return FN_SUBU;
      MN_AND:  return FN_AND;
      MN_OR:   return FN_OR;
      MN_XOR:  return FN_XOR;
      MN_NOR:  return FN_NOR;
      MN_SLT:  return FN_SLT;
      MN_SLTU: return FN_SLTU;
      MN_SLL:  return FN_SLL;
      MN_SRL:  return FN_SRL;
      MN_SRA:  return FN_SRA;
      MN_SLLV: return FN_SLLV;
      MN_SRLV: return FN_SRLV;
      MN_SRAV: return FN_SRAV;
      MN_JR:   return FN_JR;
      MN_JALR: return FN_JALR;
      default: return 6'h00;
    endcase
  endfunction
  function automatic logic [5:0] opcode_of(input logic [4:0] m);
    case (m)
      MN_ADDI: return OP_ADDI;
      MN_SLTI: return OP_SLTI;
      MN_ANDI: return OP_ANDI;
      MN_ORI:  return OP_ORI;
      MN_LUI:  return OP_LUI;
      MN_LW:   return OP_LW;
      MN_SW:   return OP_SW;
      MN_BEQ:  return OP_BEQ;
      MN_BNE:  return OP_BNE;
      MN_J:    return OP_J;
      MN_JAL:  return OP_JAL;
      default: return OP_RTYPE;
    endcase
  endfunction
endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational mnemonic+fields to 32-bit MIPS word with unused-field forcing
module instr_pack import mips_enc_pkg::*; (
  input  logic [4:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic        legal,
  output logic        is_end,
  output logic [31:0] word
);
  logic r_type, i_type, shift_imm;
  logic [4:0] rs_f, rt_f, rd_f, sh_f;
  assign r_type = mnem <= MN_JALR;
  assign i_type = mnem >= MN_ADDI && mnem <= MN_BNE;
  assign shift_imm = mnem inside {MN_SLL, MN_SRL, MN_SRA};
  assign rs_f = (shift_imm || mnem == MN_LUI) ? 5'd0 : rs;
  assign rt_f = (mnem inside {MN_JR, MN_JALR}) ? 5'd0 : rt;
  assign rd_f = mnem == MN_JR ? 5'd0 : rd;
  assign sh_f = shift_imm ? shamt : 5'd0;
  assign legal = mnem <= MN_JAL;
  assign is_end = mnem == MN_END;
  always_comb
    word = r_type ? {OP_RTYPE, rs_f, rt_f, rd_f, sh_f, funct_of(mnem)} :
           i_type ? {opcode_of(mnem), rs_f, rt_f, imm} : {opcode_of(mnem), target};
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streams symbolic MIPS instructions into consecutive instruction-memory words
module instr_encoder import mips_enc_pkg::*; #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);
  state_t state, next;
  logic legal, is_end, fire, full, wr, restart;
  logic [31:0] word;
  instr_pack u_pack (
    .mnem(in_mnem), .rs(in_rs), .rt(in_rt), .rd(in_rd), .shamt(in_shamt),
    .imm(in_imm), .target(in_target), .legal(legal), .is_end(is_end), .word(word)
  );
  assign in_ready = state == RUN;
  assign busy = state == RUN;
  assign done = state == DONE;
  assign err = state == ERR;
  assign fire = in_valid && in_ready;
  assign full = count == DEPTH;
  assign wr = fire && legal && !full;
  assign restart = state != RUN && start;
  always_comb
    next = state == RUN ? (fire ? (is_end ? DONE : (legal && !full) ? RUN : ERR) : RUN) :
           start ? RUN : state;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      count <= '0;
      im_we <= 1'b0;
      im_addr <= '0;
      im_wdata <= '0;
      err_code <= EC_NONE;
    end else begin
      state <= next;
      im_we <= wr;
      if (wr) begin
        im_addr <= count[ADDR_W-1:0];
        im_wdata <= word;
      end
      count <= restart ? '0 : count + {{ADDR_W{1'b0}}, wr};
      err_code <= restart ? EC_NONE :
                  (fire && !is_end && !legal) ? EC_ILLEGAL :
                  (fire && !is_end && full) ? EC_OVERFLOW : err_code;
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized scoreboard bench for instr_encoder against a behavioural model
module tb_instr_encoder;
  localparam int AW = 2;
  localparam int DEPTH = 4;
  localparam int FN [18] = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 0, 2, 3, 4, 6, 7, 8, 9};
  localparam int OPC [11] = '{8, 10, 12, 13, 15, 35, 43, 4, 5, 2, 3};
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic in_ready, im_we, busy, done, err;
  logic [4:0] in_mnem = '0, in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic [AW-1:0] im_addr;
  logic [31:0] im_wdata;
  logic [AW:0] count;
  logic [1:0] err_code;
  typedef struct {int addr; bit [31:0] w;} wr_t;
  wr_t q[$];
  int errors = 0, checks = 0;
  int m_state = 0, m_count = 0, m_ec = 0;
  bit armed = 1'b0;
  instr_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target), .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .count(count), .busy(busy), .done(done), .err(err), .err_code(err_code)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit [31:0] enc(int m, int rs, int rt, int rd, int sh, int imm, int tg);
    bit [31:0] w;
    if (m < 18) begin
      if (m >= 10 && m <= 12) rs = 0; else sh = 0;
      if (m == 16) begin rt = 0; rd = 0; end
      if (m == 17) rt = 0;
      w = 32'(rs) * 32'h20_0000 + 32'(rt) * 32'h1_0000 + 32'(rd) * 32'h800 + 32'(sh) * 32'd64 + 32'(FN[m]);
    end else if (m < 27) begin
      if (m == 22) rs = 0;
      w = 32'(OPC[m-18]) * 32'h400_0000 + 32'(rs) * 32'h20_0000 + 32'(rt) * 32'h1_0000 + 32'(imm);
    end else
      w = 32'(OPC[m-18]) * 32'h400_0000 + 32'(tg);
    return w;
  endfunction
  task automatic fld(int m, int rs, int rt, int rd, int sh, int imm, int tg);
    in_mnem = 5'(m); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd); in_shamt = 5'(sh);
    in_imm = 16'(imm); in_target = 26'(tg);
  endtask
  task automatic check_status();
    check("status{busy,done,err,err_code,count}", {busy, done, err, err_code, count},
          {m_state == 1, m_state == 2, m_state == 3, 2'(m_ec), 3'(m_count)});
  endtask
  task automatic step(input bit st, input bit v, input bit r);
    int m;
    start = st; in_valid = v; rst = r;
    check("in_ready", in_ready, m_state == 1);
    @(posedge clk);
    m = int'(in_mnem);
    if (r) begin
      m_state = 0; m_count = 0; m_ec = 0;
    end else if (m_state == 1) begin
      if (v) begin
        if (m == 31) m_state = 2;
        else if (m >= 29) begin m_state = 3; m_ec = 1; end
        else if (m_count == DEPTH) begin m_state = 3; m_ec = 2; end
        else begin
          q.push_back('{m_count, enc(m, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target)});
          m_count++;
        end
      end
    end else if (st) begin
      m_state = 1; m_count = 0; m_ec = 0;
    end
    #1;
    start = 1'b0; in_valid = 1'b0; rst = 1'b0;
    check_status();
    if (r) check("reset_outputs{im_addr,im_wdata}", {im_addr, im_wdata}, '0);
  endtask
  always @(negedge clk)
    if (armed) begin : mon
      wr_t e;
      check("im_we", im_we, q.size() > 0);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (im_we === 1'b1) begin
          check("im_addr", im_addr, e.addr);
          check("im_wdata", im_wdata, e.w);
        end
      end
    end
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    armed = 1'b1;
    check_status();
    check("reset{in_ready,im_we,im_addr,im_wdata}", {in_ready, im_we, im_addr, im_wdata}, '0);
    fld(18, 0, 8, 0, 0, 16'h0005, 0);
    step(1, 1, 0);
    step(0, 1, 0);
    step(1, 0, 0);
    fld(0, 8, 9, 10, 3, 0, 0);
    step(0, 1, 0);
    fld(10, 7, 8, 9, 2, 0, 0);
    step(0, 1, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    fld(23, 29, 8, 0, 0, 4, 0);
    step(0, 1, 0);
    fld(25, 8, 0, 0, 0, 16'hFFFF, 0);
    step(0, 1, 0);
    fld(27, 0, 0, 0, 0, 0, 26'h10);
    step(0, 1, 0);
    fld(31, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      fld(1, i, i + 1, i + 2, 7, 0, 0);
      step(0, 1, 0);
    end
    step(0, 1, 0);
    step(1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      fld(17, 31, 30, 29, 28, 0, 0);
      step(0, 1, 0);
    end
    fld(31, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0);
    step(1, 0, 0);
    fld(29, 1, 2, 3, 4, 5, 6);
    step(0, 1, 0);
    step(1, 0, 0);
    fld(20, 3, 4, 5, 6, 16'h1234, 0);
    step(0, 1, 0);
    fld(22, 9, 10, 11, 12, 16'hBEEF, 0);
    step(0, 1, 1);
    check("im_we_after_rst", im_we, 1'b0);
    step(0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      int sel, m;
      sel = $urandom_range(0, 19);
      m = sel < 15 ? $urandom_range(0, 28) : sel < 17 ? 31 : sel < 18 ? $urandom_range(29, 30) : $urandom_range(0, 31);
      fld(m, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
          $urandom_range(0, 31), $urandom_range(0, 65535), $urandom_range(0, 26'h3FFFFFF));
      step($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0);
    end
    step(0, 0, 0);
    step(0, 0, 0);
    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
